// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between ALU, LSU and CSR.
// The winner is accepted combinationally and appears on w_ena/w_addr/w_data one cycle later.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              src0_valid,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  input  logic              src2_valid,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic [DATA_W-1:0] src2_data,
  output logic              src2_ready,
  output logic              w_ena,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [CNT_W-1:0]  contention
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [1:0]        ptr;
  logic [1:0]        ptr_eff;
  logic [1:0]        ptr_next;
  logic [2:0]        valid;
  logic [2:0]        grant;
  logic              any_grant;
  logic              multi_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  assign valid       = {src2_valid, src1_valid, src0_valid};
  // An illegal pointer value of 3 is searched as if it were 0.
  assign ptr_eff     = (ptr == 2'd3) ? 2'd0 : ptr;
  assign multi_valid = (valid[0] & valid[1]) | (valid[0] & valid[2]) | (valid[1] & valid[2]);
  assign any_grant   = |grant;
  assign src0_ready  = grant[0];
  assign src1_ready  = grant[1];
  assign src2_ready  = grant[2];

  always_comb begin
    grant = 3'b000;
    if (rst || flush) begin
      grant = 3'b000;
    end else begin
      case (ptr_eff)
        2'd0: begin
          if (valid[0])      grant = 3'b001;
          else if (valid[1]) grant = 3'b010;
          else if (valid[2]) grant = 3'b100;
          else               grant = 3'b000;
        end
        2'd1: begin
          if (valid[1])      grant = 3'b010;
          else if (valid[2]) grant = 3'b100;
          else if (valid[0]) grant = 3'b001;
          else               grant = 3'b000;
        end
        2'd2: begin
          if (valid[2])      grant = 3'b100;
          else if (valid[0]) grant = 3'b001;
          else if (valid[1]) grant = 3'b010;
          else               grant = 3'b000;
        end
        default: grant = 3'b000;
      endcase
    end
  end

  always_comb begin
    win_addr = ADDR_ZERO;
    win_data = DATA_ZERO;
    ptr_next = ptr_eff;
    case (grant)
      3'b001: begin win_addr = src0_addr; win_data = src0_data; ptr_next = 2'd1; end
      3'b010: begin win_addr = src1_addr; win_data = src1_data; ptr_next = 2'd2; end
      3'b100: begin win_addr = src2_addr; win_data = src2_data; ptr_next = 2'd0; end
      default: begin win_addr = ADDR_ZERO; win_data = DATA_ZERO; ptr_next = ptr_eff; end
    endcase
  end

  // Writes to x0 are accepted and rotate priority but never raise w_ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 2'd0;
      w_ena      <= 1'b0;
      w_addr     <= ADDR_ZERO;
      w_data     <= DATA_ZERO;
      contention <= {CNT_W{1'b0}};
    end else begin
      if (any_grant) begin
        w_ena  <= (win_addr != ADDR_ZERO);
        w_addr <= win_addr;
        w_data <= win_data;
        ptr    <= ptr_next;
      end else begin
        w_ena  <= 1'b0;
      end
      if (multi_valid && !flush && (contention != CNT_MAX)) begin
        contention <= contention + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations, then random
// traffic compared each cycle against a queue-free behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        v [3];
  logic [4:0]  a [3];
  logic [63:0] d [3];

  logic        src0_ready, src1_ready, src2_ready;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic [31:0] contention;

  logic        r0_4, r1_4, r2_4, w_ena4;
  logic [4:0]  w_addr4;
  logic [63:0] w_data4;
  logic [3:0]  contention4;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int                m_ptr;
  logic              m_wena;
  logic [4:0]        m_waddr;
  logic [63:0]       m_wdata;
  longint unsigned   m_cnt;
  int                m_cnt4;
  logic              m_acc [3];

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(v[0]), .src0_addr(a[0]), .src0_data(d[0]), .src0_ready(src0_ready),
    .src1_valid(v[1]), .src1_addr(a[1]), .src1_data(d[1]), .src1_ready(src1_ready),
    .src2_valid(v[2]), .src2_addr(a[2]), .src2_data(d[2]), .src2_ready(src2_ready),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data), .contention(contention)
  );

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(v[0]), .src0_addr(a[0]), .src0_data(d[0]), .src0_ready(r0_4),
    .src1_valid(v[1]), .src1_addr(a[1]), .src1_data(d[1]), .src1_ready(r1_4),
    .src2_valid(v[2]), .src2_addr(a[2]), .src2_data(d[2]), .src2_ready(r2_4),
    .w_ena(w_ena4), .w_addr(w_addr4), .w_data(w_data4), .contention(contention4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First valid source searching from p, p+1, p+2 (mod 3); -1 when none.
  function automatic int pick(input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  function automatic int nvalid();
    int n = 0;
    for (int i = 0; i < 3; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [63:0] exp_rdy();
    int g;
    if (rst || flush) return 64'd0;
    g = pick(m_ptr);
    if (g < 0) return 64'd0;
    return 64'(1 << g);
  endfunction

  function automatic int grant_now();
    if (flush) return -1;
    return pick(m_ptr);
  endfunction

  // Model update: one retirement per edge, winner visible on the next cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr   <= 0;
      m_wena  <= 1'b0;
      m_waddr <= 5'd0;
      m_wdata <= 64'd0;
      m_cnt   <= 64'd0;
      m_cnt4  <= 0;
      for (int i = 0; i < 3; i++) m_acc[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) m_acc[i] <= (grant_now() == i);
      if (grant_now() >= 0) begin
        m_wena  <= (a[grant_now()] != 5'd0);
        m_waddr <= a[grant_now()];
        m_wdata <= d[grant_now()];
        m_ptr   <= (grant_now() + 1) % 3;
      end else begin
        m_wena  <= 1'b0;
      end
      if (!flush && nvalid() >= 2) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt <= m_cnt + 64'd1;
        if (m_cnt4 < 15) m_cnt4 <= m_cnt4 + 1;
      end
    end
  end

  // Compare process: every negedge, both instances against the model.
  always @(negedge clk) begin
    chk("ready", 64'({src2_ready, src1_ready, src0_ready}), exp_rdy());
    chk("ready4", 64'({r2_4, r1_4, r0_4}), exp_rdy());
    chk("w_ena", 64'(w_ena), 64'(m_wena));
    chk("w_addr", 64'(w_addr), 64'(m_waddr));
    chk("w_data", w_data, m_wdata);
    chk("contention", 64'(contention), m_cnt);
    chk("contention4", 64'(contention4), 64'(m_cnt4));
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; a[i] = 5'd0; d[i] = 64'd0;
    end
    #2;
    chk("rst_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'd0);
    chk("rst_w_ena", 64'(w_ena), 64'd0);
    chk("rst_w_data", w_data, 64'd0);
    chk("rst_cont", 64'(contention), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single ALU write to x5
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 64'h1234;
    @(negedge clk);
    chk("t1_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'd1);
    @(posedge clk); #1 v[0] = 1'b0;
    @(negedge clk);
    chk("t1_w_ena", 64'(w_ena), 64'd1);
    chk("t1_w_addr", 64'(w_addr), 64'd5);
    chk("t1_w_data", w_data, 64'h1234);

    // Asynchronous reset between edges
    #1 rst = 1'b1;
    #1;
    chk("t5_w_ena", 64'(w_ena), 64'd0);
    chk("t5_w_addr", 64'(w_addr), 64'd0);
    chk("t5_cont", 64'(contention), 64'd0);
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; a[i] = 5'(i + 1); d[i] = 64'hA0 + 64'(i);
    end
    #1;
    chk("t5_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // All three valid from reset: rotation 0,1,2,0,1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'(1 << (i % 3)));
      chk("t2_cont", 64'(contention), 64'(i));
    end

    // Two flushed cycles with everything valid
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("t4_ready_a", 64'({src2_ready, src1_ready, src0_ready}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_ready_b", 64'({src2_ready, src1_ready, src0_ready}), 64'd0);
    chk("t4_w_ena", 64'(w_ena), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t4_ptr_kept", 64'({src2_ready, src1_ready, src0_ready}), 64'd4);
    chk("t4_cont_kept", 64'(contention), 64'd5);
    chk("t4_w_ena_b", 64'(w_ena), 64'd0);

    // x0 write from LSU with ptr=1, then contended cycle goes to CSR
    @(posedge clk); #1 v[1] = 1'b0; v[2] = 1'b0; a[0] = 5'd9;
    @(negedge clk);
    chk("t3_pre", 64'({src2_ready, src1_ready, src0_ready}), 64'd1);
    @(posedge clk); #1 v[0] = 1'b0; v[1] = 1'b1; a[1] = 5'd0; d[1] = 64'hBEEF;
    @(negedge clk);
    chk("t3_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'd2);
    chk("t3_w_addr9", 64'(w_addr), 64'd9);
    @(posedge clk); #1 v[0] = 1'b1; v[2] = 1'b1; a[2] = 5'd7;
    @(negedge clk);
    chk("t3_w_ena", 64'(w_ena), 64'd0);
    chk("t3_next", 64'({src2_ready, src1_ready, src0_ready}), 64'd4);
    chk("t3_cont", 64'(contention), 64'd6);

    // Narrow counter saturates while the wide one keeps counting
    @(posedge clk); #1 v[2] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_cont4", 64'(contention4), 64'd15);
    chk("t6_cont", 64'(contention), 64'd27);

    // Random traffic obeying the hold-until-ready protocol
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      flush = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || m_acc[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          a[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
          d[i] = {$urandom, $urandom};
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rnd_rst_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'd0);
        chk("rnd_rst_w_ena", 64'(w_ena), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
